// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-byte SPI master for the spiMemory slave.
// Frame = {addr[6:0], rw} command byte then one data byte, MSB first.
// sclk idles low; the slave samples mosi on the sclk rising edge; the master
// captures miso on the last clk cycle of each DATA high half.
module spi_master_ctrl #(
  parameter int CLK_DIV        = 4,  // clk cycles per sclk half-period (>= 2)
  parameter int CS_IDLE_CYCLES = 8   // minimum cs-high cycles between frames (>= 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       abort,
  output logic       rsp_valid,
  output logic       rsp_aborted,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    DATA,
    FINISH,
    GAP
  } state_t;

  state_t      state;
  state_t      state_d;

  logic [15:0] cnt;      // clk cycles spent in the current phase / half
  logic        half;     // 0 = sclk low half, 1 = sclk high half
  logic [2:0]  bit_cnt;  // bit index within CMD or DATA
  logic [15:0] tx_sr;    // {command byte, write data}, MSB drives mosi
  logic [7:0]  rx_sr;    // miso capture, shifted in MSB first
  logic        rw_q;     // latched read/write flag of the frame in flight

  logic        active;
  logic        div_end;
  logic        gap_end;
  logic        bit_last;
  logic        accept;
  logic        aborting;
  logic        done;

  // Next-state decode, abort override and combinational pin drive.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d   = state;
    accept    = 1'b0;
    active    = (state == SETUP) || (state == CMD) || (state == DATA) || (state == FINISH);
    div_end   = (cnt == DIV_LAST);
    gap_end   = (cnt == GAP_LAST);
    bit_last  = half && div_end && (bit_cnt == 3'd7);
    aborting  = active && abort;

    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:   if (div_end)  state_d = CMD;
      CMD:     if (bit_last) state_d = DATA;
      DATA:    if (bit_last) state_d = FINISH;
      FINISH:  if (div_end)  state_d = GAP;
      GAP:     if (gap_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort beats any normal progression; IDLE and GAP are not active so it
    // is ignored there, which also makes a same-cycle accept win.
    if (aborting) state_d = GAP;

    done      = (state == FINISH) && div_end && !abort;

    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    cs        = !active;
    sclk      = ((state == CMD) || (state == DATA)) && half;
    mosi      = 1'b0;
    if ((state == SETUP) || (state == CMD) || ((state == DATA) && !rw_q)) begin
      mosi = tx_sr[15];
    end
  end

  // State register, phase counters, shift registers and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    if (reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      half        <= 1'b0;
      bit_cnt     <= 3'd0;
      tx_sr       <= 16'd0;
      rx_sr       <= 8'd0;
      rw_q        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_aborted <= 1'b0;
      rsp_rdata   <= 8'h00;
    end else begin
      state       <= state_d;
      rsp_valid   <= done || aborting;
      rsp_aborted <= aborting;
      if (done) rsp_rdata <= rw_q ? rx_sr : 8'h00;

      // Counters restart on every state change; CMD/DATA split into halves.
      if (state_d != state) begin
        cnt     <= 16'd0;
        half    <= 1'b0;
        bit_cnt <= 3'd0;
      end else if ((state == CMD) || (state == DATA)) begin
        if (div_end) begin
          cnt  <= 16'd0;
          half <= ~half;
          if (half) bit_cnt <= bit_cnt + 3'd1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 16'd1;
      end

      // Shift at the end of each high half so mosi moves on the first low-half cycle.
      if (accept) begin
        tx_sr <= {req_addr, req_rw, req_wdata};
        rw_q  <= req_rw;
        rx_sr <= 8'd0;
      end else if (((state == CMD) || (state == DATA)) && half && div_end) begin
        tx_sr <= {tx_sr[14:0], 1'b0};
      end

      // miso is captured just before sclk falls, giving the slave a full high half.
      if ((state == DATA) && half && div_end) begin
        rx_sr <= {rx_sr[6:0], miso};
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=2) share one
// behavioural spiMemory slave through a select mux. Expected responses go into
// a scoreboard queue; a negedge monitor pops and compares on every rsp_valid.
module tb_spi_master_ctrl;

  localparam int CS_IDLE = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       abort = 1'b0;
  logic       sel = 1'b0;  // 0 = CLK_DIV 4 instance, 1 = CLK_DIV 2 instance
  logic       miso;

  logic       req_ready0, rsp_valid0, rsp_aborted0, busy0, sclk0, cs0, mosi0;
  logic       req_ready1, rsp_valid1, rsp_aborted1, busy1, sclk1, cs1, mosi1;
  logic [7:0] rsp_rdata0, rsp_rdata1;

  logic       bus_req_ready, bus_rsp_valid, bus_rsp_aborted, bus_busy;
  logic       bus_sclk, bus_cs, bus_mosi;
  logic [7:0] bus_rsp_rdata;

  always #5 clk = ~clk;

  spi_master_ctrl #(.CLK_DIV(4), .CS_IDLE_CYCLES(CS_IDLE)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(req_ready0),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .abort(abort & ~sel),
    .rsp_valid(rsp_valid0), .rsp_aborted(rsp_aborted0), .rsp_rdata(rsp_rdata0),
    .busy(busy0), .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso)
  );

  spi_master_ctrl #(.CLK_DIV(2), .CS_IDLE_CYCLES(CS_IDLE)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(req_ready1),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .abort(abort & sel),
    .rsp_valid(rsp_valid1), .rsp_aborted(rsp_aborted1), .rsp_rdata(rsp_rdata1),
    .busy(busy1), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso)
  );

  assign bus_req_ready   = sel ? req_ready1   : req_ready0;
  assign bus_rsp_valid   = sel ? rsp_valid1   : rsp_valid0;
  assign bus_rsp_aborted = sel ? rsp_aborted1 : rsp_aborted0;
  assign bus_rsp_rdata   = sel ? rsp_rdata1   : rsp_rdata0;
  assign bus_busy        = sel ? busy1        : busy0;
  assign bus_sclk        = sel ? sclk1        : sclk0;
  assign bus_cs          = sel ? cs1          : cs0;
  assign bus_mosi        = sel ? mosi1        : mosi0;

  typedef struct {
    logic        aborted;
    logic [7:0]  rdata;
    logic [15:0] frame;
    int          cs_len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired before the expected event (t=%0t)", name, $time);
  endtask

  // ---------------- spiMemory slave model ----------------
  logic [7:0]  mem [128];
  int          slv_cnt = 0;
  logic [15:0] slv_frame = 16'h0000;
  logic [7:0]  slv_cmd = 8'h00;
  logic [7:0]  slv_byte;

  initial foreach (mem[i]) mem[i] = 8'h00;

  // Rising sclk shifts mosi in; cs falling starts a new frame.
  always @(posedge bus_sclk or negedge bus_cs) begin
    if (bus_sclk) begin
      slv_frame = {slv_frame[14:0], bus_mosi};
      slv_cnt++;
      if (slv_cnt == 8) slv_cmd = slv_frame[7:0];
      if (slv_cnt == 16 && !slv_cmd[0]) mem[slv_cmd[7:1]] = slv_frame[7:0];
    end else begin
      slv_cnt   = 0;
      slv_frame = 16'h0000;
    end
  end

  // Read data bit 7-i is presented from the (9+i)th rising edge onward.
  always_comb begin
    slv_byte = mem[slv_cmd[7:1]];
    miso     = 1'b0;
    if (slv_cmd[0] && slv_cnt >= 9 && slv_cnt <= 16) miso = slv_byte[3'(16 - slv_cnt)];
  end

  // ---------------- monitor ----------------
  int cs_lo = 0, cs_hi = 0, last_cs_lo = 0, last_cs_hi = 0;

  always @(negedge clk) begin
    if (bus_cs === 1'b0) begin
      if (cs_hi != 0) begin
        last_cs_hi = cs_hi;
        cs_hi      = 0;
      end
      cs_lo++;
    end else begin
      if (cs_lo != 0) begin
        last_cs_lo = cs_lo;
        cs_lo      = 0;
      end
      cs_hi++;
    end
    if (bus_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with nothing expected (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_aborted", 32'(bus_rsp_aborted), 32'(mon_e.aborted));
        check("rsp_rdata", 32'(bus_rsp_rdata), 32'(mon_e.rdata));
        if (!mon_e.aborted) begin
          check("mosi_frame", 32'(slv_frame), 32'(mon_e.frame));
          check("cs_low_cycles", 32'(last_cs_lo), 32'(mon_e.cs_len));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic ab, input logic [7:0] rdata);
    exp_t e;
    e.aborted = ab;
    e.rdata   = rdata;
    e.frame   = {addr, rw, (rw ? 8'h00 : wdata)};
    e.cs_len  = 34 * (sel ? 2 : 4);
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus_req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus_req_ready !== 1'b1) bound_fail("req_ready_wait");
  endtask

  // Drive one request for a single cycle; returns with the frame in SETUP.
  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
    wait_ready();
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                       input logic ab, input logic [7:0] rdata);
    push_exp(rw, addr, wdata, ab, rdata);
    send(rw, addr, wdata);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      bound_fail("rsp_wait");
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_slv(input int target);
    int n = 0;
    while (slv_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (slv_cnt < target) bound_fail("sclk_edge_wait");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_cs", 32'(bus_cs), 32'd1);
    check("reset_sclk", 32'(bus_sclk), 32'd0);
    check("reset_mosi", 32'(bus_mosi), 32'd0);
    check("reset_busy", 32'(bus_busy), 32'd0);
    check("reset_rsp_valid", 32'(bus_rsp_valid), 32'd0);
    check("reset_rsp_aborted", 32'(bus_rsp_aborted), 32'd0);
    check("reset_rsp_rdata", 32'(bus_rsp_rdata), 32'h00);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus_req_ready), 32'd1);

    // 1: write 0x04 <- 0xF0, frame 0x08F0
    issue(1'b0, 7'h04, 8'hF0, 1'b0, 8'h00);
    wait_rsp();
    check("mem_04_after_write", 32'(mem[7'h04]), 32'hF0);

    // 2: read 0x04, frame 0x0900
    issue(1'b1, 7'h04, 8'h5A, 1'b0, 8'hF0);
    wait_rsp();

    // 3: write 0x04 <- 0x00 aborted after 4 DATA rising edges
    issue(1'b0, 7'h04, 8'h00, 1'b1, 8'hF0);
    wait_slv(12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs", 32'(bus_cs), 32'd1);
    check("abort_sclk", 32'(bus_sclk), 32'd0);
    check("abort_mosi", 32'(bus_mosi), 32'd0);
    check("abort_busy_in_gap", 32'(bus_busy), 32'd1);
    wait_rsp();
    check("mem_04_after_abort", 32'(mem[7'h04]), 32'hF0);
    issue(1'b1, 7'h04, 8'h00, 1'b0, 8'hF0);
    wait_rsp();

    // 4: req_valid held high across two back-to-back writes
    push_exp(1'b0, 7'h0C, 8'h0F, 1'b0, 8'h00);
    push_exp(1'b0, 7'h0D, 8'hAA, 1'b0, 8'h00);
    wait_ready();
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 7'h0C;
    req_wdata = 8'h0F;
    @(negedge clk);
    req_addr  = 7'h0D;
    req_wdata = 8'hAA;
    check("ready_low_while_busy", 32'(bus_req_ready), 32'd0);
    check("busy_high_in_frame", 32'(bus_busy), 32'd1);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp();
    check("cs_high_between_frames", 32'(last_cs_hi), 32'(CS_IDLE + 1));
    check("mem_0c", 32'(mem[7'h0C]), 32'h0F);
    check("mem_0d", 32'(mem[7'h0D]), 32'hAA);

    // 5: reset in the middle of CMD; no response may appear
    send(1'b0, 7'h0C, 8'h55);
    wait_slv(4);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_cs", 32'(bus_cs), 32'd1);
    check("midreset_sclk", 32'(bus_sclk), 32'd0);
    check("midreset_mosi", 32'(bus_mosi), 32'd0);
    check("midreset_busy", 32'(bus_busy), 32'd0);
    check("midreset_rsp_valid", 32'(bus_rsp_valid), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mem_0c_after_reset", 32'(mem[7'h0C]), 32'h0F);
    issue(1'b1, 7'h0C, 8'h00, 1'b0, 8'h0F);
    wait_rsp();

    // 6: CLK_DIV=2 instance reads 0x0D, cs low 68 cycles
    sel = 1'b1;
    @(negedge clk);
    issue(1'b1, 7'h0D, 8'h00, 1'b0, 8'hAA);
    wait_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
